// File: rtl/ex_pkg.sv
// Shared encodings for the LEGv8 execute stage: ALU control codes, operand-B
// selects, ALUOp classes, opcode match constants and the ALU decode function.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_MUL   = 4'b1000,
    ALU_NOR   = 4'b1100
  } alu_ctl_e;

  localparam logic [1:0] SRC_RS2     = 2'b00;
  localparam logic [1:0] SRC_IMM     = 2'b01;
  localparam logic [1:0] SRC_IMM12   = 2'b10;
  localparam logic [1:0] SRC_ILLEGAL = 2'b11;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CB  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // R-format opcodes, instr[31:21]; NOR uses a local encoding
  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;
  localparam logic [10:0] OPC_NOR = 11'b11101010001;

  // I-format opcodes, instr[31:22]
  localparam logic [9:0] OPI_ADDI = 10'b1001000100;
  localparam logic [9:0] OPI_SUBI = 10'b1101000100;
  localparam logic [9:0] OPI_ANDI = 10'b1001001000;
  localparam logic [9:0] OPI_ORRI = 10'b1011001000;

  typedef struct packed {
    logic     ok;
    alu_ctl_e code;
  } alu_dec_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic illegal;
  } ex_ctl_t;

  typedef struct packed {
    logic b;
    logic bz;
    logic bnz;
  } br_t;

  function automatic alu_dec_t alu_decode(input logic [1:0] alu_op, input logic [10:0] opc);
    alu_dec_t d;
    d.ok   = 1'b1;
    d.code = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: d.code = ALU_ADD;
      ALUOP_CB:  d.code = ALU_PASSB;
      ALUOP_R: begin
        case (opc)
          OPC_ADD: d.code = ALU_ADD;
          OPC_SUB: d.code = ALU_SUB;
          OPC_AND: d.code = ALU_AND;
          OPC_ORR: d.code = ALU_ORR;
          OPC_NOR: d.code = ALU_NOR;
          OPC_MUL: d.code = ALU_MUL;
          default: d.ok   = 1'b0;
        endcase
      end
      default: begin
        case (opc[10:1])
          OPI_ADDI: d.code = ALU_ADD;
          OPI_SUBI: d.code = ALU_SUB;
          OPI_ANDI: d.code = ALU_AND;
          OPI_ORRI: d.code = ALU_ORR;
          default:  d.ok   = 1'b0;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// ID/EX in, EX/MEM out and flush bundle of the execute stage.
interface ex_stage_pipe_if #(parameter int unsigned XLEN = 64);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [1:0]      alu_src;
  logic [1:0]      alu_op;
  logic            b;
  logic            bz;
  logic            bnz;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic            reg_write;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] branch_addr;
  logic            pc_src;
  logic            zero;
  logic [4:0]      rd;
  logic [4:0]      ctl_out;

  modport master (
    output flush, in_valid, pc, instr, imm, rs1_data, rs2_data, alu_src, alu_op,
           b, bz, bnz, mem_read, mem_write, mem_to_reg, reg_write, out_ready,
    input  in_ready, out_valid, result, store_data, branch_addr, pc_src, zero, rd, ctl_out
  );

  modport slave (
    input  flush, in_valid, pc, instr, imm, rs1_data, rs2_data, alu_src, alu_op,
           b, bz, bnz, mem_read, mem_write, mem_to_reg, reg_write, out_ready,
    output in_ready, out_valid, result, store_data, branch_addr, pc_src, zero, rd, ctl_out
  );
endinterface

// File: rtl/ex_stage_pipe_mul.sv
// Iterative shift-add multiplier: XLEN/MUL_STEPS multiplier bits per cycle,
// first chunk folded in on the start edge so done rises MUL_STEPS-1 edges later.
module iter_mul #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned MUL_STEPS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int unsigned CHUNK = XLEN / MUL_STEPS;
  localparam int unsigned CW    = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam int unsigned LAST  = (MUL_STEPS > 1) ? MUL_STEPS - 2 : 0;

  logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] pp_start, pp_step;

  function automatic logic [XLEN-1:0] partial(input logic [XLEN-1:0] x, input logic [CHUNK-1:0] m);
    logic [XLEN-1:0] s;
    s = '0;
    for (int j = 0; j < int'(CHUNK); j++) begin
      if (m[j]) s = s + (x << j);
    end
    return s;
  endfunction

  assign pp_start = partial(a, b[CHUNK-1:0]);
  assign pp_step  = partial(mcand_q, mplier_q[CHUNK-1:0]);
  assign done     = done_q;
  assign product  = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      mcand_q  <= a << CHUNK;
      mplier_q <= b >> CHUNK;
      acc_q    <= pp_start;
      cnt_q    <= '0;
      busy_q   <= (MUL_STEPS > 1);
      done_q   <= (MUL_STEPS == 1);
    end else if (busy_q) begin
      acc_q    <= acc_q + pp_step;
      mcand_q  <= mcand_q << CHUNK;
      mplier_q <= mplier_q >> CHUNK;
      cnt_q    <= cnt_q + CW'(1);
      if (cnt_q == CW'(LAST)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_stage_pipe.sv
// LEGv8 execute stage with iterative MUL; all EX/MEM outputs are registered,
// in_ready is the only combinational output.
module ex_stage_pipe #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned MUL_STEPS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  ex_stage_pipe_if.slave  bus
);
  import ex_pkg::*;

  typedef enum logic {IDLE, MUL_BUSY} state_e;

  state_e          state_q;
  logic            out_valid_q, zero_q, pc_src_q;
  logic [XLEN-1:0] result_q, store_q, baddr_q;
  logic [4:0]      rd_q;
  ex_ctl_t         ctl_q;

  logic [XLEN-1:0] pend_store_q, pend_baddr_q;
  logic [4:0]      pend_rd_q;
  ex_ctl_t         pend_ctl_q;
  br_t             pend_br_q;

  alu_dec_t        dec;
  logic [XLEN-1:0] opb, alu_res, in_baddr;
  ex_ctl_t         in_ctl;
  br_t             in_br;
  logic            in_ready_c, accept, is_mul, load, mul_done;
  logic [XLEN-1:0] mul_product;

  logic [XLEN-1:0] result_d, store_d, baddr_d;
  logic [4:0]      rd_d;
  ex_ctl_t         ctl_d;
  br_t             br_d;
  logic            zero_d, pc_src_d;

  logic            unused_instr;
  assign unused_instr = ^bus.instr[9:5];

  assign dec        = alu_decode(bus.alu_op, bus.instr[31:21]);
  assign in_ready_c = !rst && !bus.flush && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign is_mul     = dec.ok && (dec.code == ALU_MUL);
  assign load       = (state_q == IDLE) ? (accept && !is_mul) : mul_done;
  assign in_baddr   = bus.pc + (bus.imm << 2);
  assign in_br      = '{b: bus.b, bz: bus.bz, bnz: bus.bnz};

  // Operand B, ALU and control bits for the op currently on the ID/EX side
  always_comb begin
    opb = '0;
    case (bus.alu_src)
      SRC_RS2:   opb = bus.rs2_data;
      SRC_IMM:   opb = bus.imm;
      SRC_IMM12: opb = XLEN'(bus.instr[21:10]);
      default:   opb = '0;
    endcase

    alu_res = '0;
    case (dec.code)
      ALU_AND:   alu_res = bus.rs1_data & opb;
      ALU_ORR:   alu_res = bus.rs1_data | opb;
      ALU_ADD:   alu_res = bus.rs1_data + opb;
      ALU_SUB:   alu_res = bus.rs1_data - opb;
      ALU_PASSB: alu_res = opb;
      ALU_NOR:   alu_res = ~(bus.rs1_data | opb);
      default:   alu_res = '0;
    endcase
    if (!dec.ok) alu_res = '0;

    in_ctl = '{mem_read:   bus.mem_read,
               mem_write:  bus.mem_write,
               mem_to_reg: bus.mem_to_reg,
               reg_write:  bus.reg_write,
               illegal:    (bus.alu_src == SRC_ILLEGAL) || !dec.ok};
  end

  // EX/MEM next values: from the live op, or from the parked MUL fields
  always_comb begin
    result_d = alu_res;
    store_d  = bus.rs2_data;
    baddr_d  = in_baddr;
    rd_d     = bus.instr[4:0];
    ctl_d    = in_ctl;
    br_d     = in_br;
    if (state_q == MUL_BUSY) begin
      result_d = mul_product;
      store_d  = pend_store_q;
      baddr_d  = pend_baddr_q;
      rd_d     = pend_rd_q;
      ctl_d    = pend_ctl_q;
      br_d     = pend_br_q;
    end
    zero_d   = (result_d == '0);
    pc_src_d = br_d.b | (br_d.bz & zero_d) | (br_d.bnz & ~zero_d);
  end

  iter_mul #(.XLEN(XLEN), .MUL_STEPS(MUL_STEPS)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .abort   (bus.flush),
    .a       (bus.rs1_data),
    .b       (opb),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      store_q      <= '0;
      baddr_q      <= '0;
      rd_q         <= '0;
      ctl_q        <= '0;
      zero_q       <= 1'b0;
      pc_src_q     <= 1'b0;
      pend_store_q <= '0;
      pend_baddr_q <= '0;
      pend_rd_q    <= '0;
      pend_ctl_q   <= '0;
      pend_br_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && is_mul) begin
            pend_store_q <= bus.rs2_data;
            pend_baddr_q <= in_baddr;
            pend_rd_q    <= bus.instr[4:0];
            pend_ctl_q   <= in_ctl;
            pend_br_q    <= in_br;
            out_valid_q  <= 1'b0;
            state_q      <= MUL_BUSY;
          end else if (accept) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        result_q <= result_d;
        store_q  <= store_d;
        baddr_q  <= baddr_d;
        rd_q     <= rd_d;
        ctl_q    <= ctl_d;
        zero_q   <= zero_d;
        pc_src_q <= pc_src_d;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.store_data  = store_q;
  assign bus.branch_addr = baddr_q;
  assign bus.pc_src      = pc_src_q;
  assign bus.zero        = zero_q;
  assign bus.rd          = rd_q;
  assign bus.ctl_out     = ctl_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe (XLEN=64, MUL_STEPS=16) with hand-computed expectations.
module tb_ex_stage_pipe;
  import ex_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned STEPS = 16;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_stage_pipe_if #(.XLEN(XLEN)) bus ();

  ex_stage_pipe #(.XLEN(XLEN), .MUL_STEPS(STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] ins, input logic [1:0] src,
                       input logic [63:0] a, input logic [63:0] bv, input logic [63:0] im,
                       input logic [63:0] p, input logic [2:0] br, input logic [3:0] ctl);
    bus.alu_op   = op;
    bus.instr    = ins;
    bus.alu_src  = src;
    bus.rs1_data = a;
    bus.rs2_data = bv;
    bus.imm      = im;
    bus.pc       = p;
    {bus.b, bus.bz, bus.bnz} = br;
    {bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write} = ctl;
    bus.in_valid = 1'b1;
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(ALUOP_MEM, 32'd0, SRC_RS2, 0, 0, 0, 0, 3'b000, 4'b0000);
    bus.in_valid = 1'b0;
    repeat (3) tick;
    chk_eq("rst_in_ready", 64'(bus.in_ready), 0);
    chk_eq("rst_out_valid", 64'(bus.out_valid), 0);
    chk_eq("rst_result", bus.result, 0);
    rst = 1'b0;
    #1;
    chk_eq("post_rst_in_ready", 64'(bus.in_ready), 1);

    // ADD 5 + imm 7
    drive(ALUOP_MEM, 32'd3, SRC_IMM, 5, 64'hAA, 7, 0, 3'b000, 4'b0001);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("add_valid", 64'(bus.out_valid), 1);
    chk_eq("add_result", bus.result, 12);
    chk_eq("add_zero", 64'(bus.zero), 0);
    chk_eq("add_rd", 64'(bus.rd), 3);
    chk_eq("add_ctl", 64'(bus.ctl_out), 64'h02);
    chk_eq("add_store", bus.store_data, 64'hAA);
    chk_eq("add_baddr", bus.branch_addr, 64'h1C);
    tick;
    chk_eq("add_consumed", 64'(bus.out_valid), 0);

    // SUB 9 - 9 with bz
    drive(ALUOP_R, {OPC_SUB, 21'd0}, SRC_RS2, 9, 9, 4, 64'h100, 3'b010, 4'b0000);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("sub_result", bus.result, 0);
    chk_eq("sub_zero", 64'(bus.zero), 1);
    chk_eq("sub_pc_src", 64'(bus.pc_src), 1);
    chk_eq("sub_baddr", bus.branch_addr, 64'h110);
    tick;

    // CBNZ on nonzero rs2
    drive(ALUOP_CB, 32'd0, SRC_RS2, 0, 5, 0, 0, 3'b001, 4'b0000);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("cbnz_result", bus.result, 5);
    chk_eq("cbnz_pc_src", 64'(bus.pc_src), 1);
    tick;

    // MUL 0xFFFF_FFFF * 3
    drive(ALUOP_R, {OPC_MUL, 16'd0, 5'd4}, SRC_RS2, 64'hFFFF_FFFF, 3, 0, 0, 3'b000, 4'b0001);
    tick;
    bus.in_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < int'(STEPS); k++) begin
      if (!bus.in_ready && !bus.out_valid) cnt++;
      tick;
    end
    chk_eq("mul_busy_cycles", 64'(cnt), 64'(STEPS));
    chk_eq("mul_valid", 64'(bus.out_valid), 1);
    chk_eq("mul_result", bus.result, 64'h2_FFFF_FFFD);
    chk_eq("mul_rd", 64'(bus.rd), 4);
    tick;

    // Backpressure with a second ADD pending
    bus.out_ready = 1'b0;
    drive(ALUOP_MEM, 32'd0, SRC_IMM, 1, 0, 2, 0, 3'b000, 4'b0001);
    tick;
    chk_eq("bp_first", bus.result, 3);
    drive(ALUOP_MEM, 32'd0, SRC_IMM, 10, 0, 20, 0, 3'b000, 4'b0001);
    #0;
    chk_eq("bp_in_ready", 64'(bus.in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_eq("bp_hold_result", bus.result, 3);
      chk_eq("bp_hold_valid", 64'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk_eq("bp_second", bus.result, 30);
    chk_eq("bp_second_valid", 64'(bus.out_valid), 1);
    tick;
    chk_eq("bp_drained", 64'(bus.out_valid), 0);

    // Flush on the second MUL cycle
    drive(ALUOP_R, {OPC_MUL, 21'd0}, SRC_RS2, 7, 6, 0, 0, 3'b000, 4'b0000);
    tick;
    bus.in_valid = 1'b0;
    tick;
    bus.flush = 1'b1;
    #0;
    chk_eq("flush_in_ready", 64'(bus.in_ready), 0);
    tick;
    bus.flush = 1'b0;
    #0;
    chk_eq("flush_out_valid", 64'(bus.out_valid), 0);
    chk_eq("flush_idle_ready", 64'(bus.in_ready), 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.out_valid) cnt++;
      tick;
    end
    chk_eq("flush_no_completion", 64'(cnt), 20);
    drive(ALUOP_R, {OPC_MUL, 21'd0}, SRC_RS2, 64'h1234, 64'h10, 0, 0, 3'b000, 4'b0000);
    tick;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      tick;
      cnt++;
    end
    chk_eq("mul2_latency", 64'(cnt), 64'(STEPS));
    chk_eq("mul2_result", bus.result, 64'h12340);
    tick;

    // Illegal alu_src and unmapped opcode
    drive(ALUOP_R, {OPC_AND, 21'd0}, SRC_ILLEGAL, 64'hFF, 64'hFF, 0, 0, 3'b000, 4'b0000);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("ill_src_result", bus.result, 0);
    chk_eq("ill_src_ctl", 64'(bus.ctl_out), 64'h01);
    tick;
    drive(ALUOP_R, 32'hFFE0_0000, SRC_RS2, 64'hF0, 64'h0F, 0, 0, 3'b000, 4'b0001);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("ill_opc_result", bus.result, 0);
    chk_eq("ill_opc_ctl", 64'(bus.ctl_out), 64'h03);
    tick;

    // ORRI via zero-extended instr[21:10], then NOR
    drive(ALUOP_I, {OPI_ORRI, 12'h00F, 5'd0, 5'd7}, SRC_IMM12, 64'hF0, 0, 0, 0, 3'b000, 4'b0001);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("orri_result", bus.result, 64'hFF);
    chk_eq("orri_rd", 64'(bus.rd), 7);
    tick;
    drive(ALUOP_R, {OPC_NOR, 16'd0, 5'd9}, SRC_RS2, 64'hF0, 64'h0F, 0, 0, 3'b000, 4'b1001);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("nor_result", bus.result, 64'hFFFF_FFFF_FFFF_FF00);

    // Async reset mid-MUL
    drive(ALUOP_R, {OPC_MUL, 21'd0}, SRC_RS2, 5, 5, 0, 0, 3'b000, 4'b0000);
    tick;
    bus.in_valid = 1'b0;
    repeat (3) tick;
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_result", bus.result, 0);
    chk_eq("arst_rd", 64'(bus.rd), 0);
    chk_eq("arst_ctl", 64'(bus.ctl_out), 0);
    chk_eq("arst_in_ready", 64'(bus.in_ready), 0);
    tick;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.out_valid) cnt++;
      tick;
    end
    chk_eq("arst_no_stale_mul", 64'(cnt), 20);
    drive(ALUOP_MEM, 32'd0, SRC_IMM, 1, 0, 2, 0, 3'b000, 4'b0000);
    tick;
    bus.in_valid = 1'b0;
    chk_eq("arst_recover", bus.result, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Registered, parametrised execute stage for the LEGv8 pipeline. It sits between the ID/EX and EX/MEM boundaries.
- It selects operand B, decodes ALUOp plus opcode into an ALU control code, and computes the ALU result, zero flag, branch target and branch decision.
- It adds a multi-cycle iterative multiplier (MUL), valid/ready handshakes on both sides and a flush input.
- All outputs are registered and form the EX/MEM pipeline register.

Parameters:
- XLEN, 64, datapath width in bits (must be 16 or greater).
- MUL_STEPS, XLEN, iterations of the shift-add multiplier (must divide XLEN); each iteration consumes XLEN/MUL_STEPS multiplier bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  kill the in-flight op and clear out_valid.
- in_valid  in  1  ID/EX holds a valid op.
- in_ready  out  1  stage accepts an op this cycle.
- pc  in  XLEN  instruction address.
- instr  in  32  instruction word.
- imm  in  XLEN  sign-extended immediate.
- rs1_data, rs2_data  in  XLEN  register operands.
- alu_src  in  2  operand-B select.
- alu_op  in  2  ALUOp.
- b, bz, bnz, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  control bits.
- out_valid  out  1  EX/MEM holds a result.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  ALU or MUL result.
- store_data  out  XLEN  registered rs2_data.
- branch_addr  out  XLEN  pc + (imm << 2).
- pc_src  out  1  branch taken.
- zero  out  1  result equals 0.
- rd  out  5  instr[4:0].
- ctl_out  out  5  registered {mem_read, mem_write, mem_to_reg, reg_write, illegal}.

Behaviour:
- Reset:
  - All outputs and state are cleared to 0 and the FSM goes to IDLE.
  - in_ready is 0 while rst is asserted and becomes 1 in the first cycle after release.
- Accept: an op is accepted when in_valid && in_ready, where in_ready = (state == IDLE) && (!out_valid || out_ready).
- Operand B by alu_src:
  - 00: rs2_data.
  - 01: imm.
  - 10: zero-extended instr[21:10].
  - 11: operand B = 0 and illegal = 1.
- ALU control codes (from alu_op and instr[31:21]):
  - AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100, MUL 1000.
  - Any unmapped code gives result 0 and illegal = 1. No simulation messages.
- Arithmetic: all results, including branch_addr, wrap modulo 2^XLEN. MUL returns the low XLEN bits of the unsigned product.
- State IDLE:
  - Non-MUL op accepted at edge N: EX/MEM fields are loaded at edge N and out_valid = 1 from that edge (1-cycle latency).
  - MUL op accepted: operands are latched, the step counter is set to 0 and the FSM goes to MUL_BUSY. out_valid is cleared at this edge if the old result is being consumed.
- State MUL_BUSY:
  - One iteration per cycle; in_ready = 0.
  - After MUL_STEPS iterations the EX/MEM fields are loaded, out_valid = 1 and the FSM returns to IDLE.
  - Total latency is MUL_STEPS cycles after the accept edge.
- Flags:
  - zero = (result == 0).
  - pc_src = b | (bz & zero) | (bnz & ~zero), all evaluated on the final result.
  - CBZ/CBNZ rely on decode selecting PASSB with rs2_data.
- Backpressure: while out_valid && !out_ready, all outputs hold stable and no new op is accepted.
- Result consumption: on out_valid && out_ready with no new completion in the same cycle, out_valid drops.
- Simultaneous events:
  - Consumption plus a new single-cycle accept in the same cycle: the new result replaces the old one with no bubble.
  - MUL completion while the previous result is unconsumed cannot occur, because the accept rule prevents it.
- Flush:
  - Takes priority over everything.
  - At the next edge: out_valid = 0, FSM = IDLE, the MUL is aborted and no accept occurs that cycle (in_ready = 0 while flush = 1).
- Reset mid-MUL: behaves exactly like the reset state; the partial product is discarded.

Decomposition:
- Shared package ex_pkg holds:
  - the ALU control code constants (including MUL);
  - the alu_src encodings;
  - the ALUOp encodings;
  - the opcode match constants used by the decode function.
- One sub-module, iter_mul (parameters XLEN and MUL_STEPS):
  - ports: start/a/b in, done/product out, plus an abort input;
  - it is the only other sequential unit.

Test Plan:
- Reset release, then ADD with rs1 = 5, alu_src 01, imm = 7: result = 12 and zero = 0 one cycle after accept, with out_valid = 1.
- SUB 9 − 9 with bz = 1, pc = 0x100, imm = 4: result = 0, zero = 1, pc_src = 1, branch_addr = 0x110.
- MUL 0xFFFF_FFFF × 3 (XLEN = 64): in_ready = 0 for MUL_STEPS cycles, then result = 0x2_FFFF_FFFD.
- Backpressure: out_ready held 0 for 3 cycles with a second ADD pending; outputs stay stable, then the second result appears one cycle after out_ready rises.
- Flush asserted on the 2nd cycle of a MUL: out_valid stays 0, the next op is accepted once flush is low, and a fresh MUL returns the correct product.
- Illegal alu_src 11 and an unmapped opcode: illegal = 1, result = 0 for an AND-class op. Asynchronous reset asserted mid-MUL: all outputs are 0 immediately.
